// File: rtl/clk_div_prog.sv
// -----------------------------------------------------------------------------
// clk_div_prog
//
// Purpose:
//   NCH independent programmable clock dividers that share a single input
//   clock. Each channel counts 0..R-1 and produces a registered divided clock
//   that is high for the first (R+1)/2 counts of every period. Each channel
//   also produces a one-cycle tick at the start of every period. A new ratio
//   is double-buffered: it is held in a shadow register and swapped in at the
//   next period boundary, so a running output never produces a short period.
//   A shared sync pulse restarts every enabled channel on the same edge.
//
// Ports:
//   clk      in   1            divider source clock, rising-edge active
//   reset    in   1            asynchronous, active-low reset
//   en       in   NCH          per-channel run enable
//   sync     in   1            one-cycle pulse, phase-aligns enabled channels
//   load     in   NCH          per-channel strobe capturing a new ratio
//   ratio    in   NCH*CNT_W    ratio for channel i in [i*CNT_W +: CNT_W]
//   clk_out  out  NCH          registered divided clock per channel
//   tick     out  NCH          registered pulse on each clk_out rising step
//   pending  out  NCH          captured ratio awaiting its period boundary
// -----------------------------------------------------------------------------
module clk_div_prog #(
  parameter int unsigned NCH       = 3,
  parameter int unsigned CNT_W     = 8,
  parameter int unsigned DEF_RATIO = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NCH-1:0]       en,
  input  logic                 sync,
  input  logic [NCH-1:0]       load,
  input  logic [NCH*CNT_W-1:0] ratio,
  output logic [NCH-1:0]       clk_out,
  output logic [NCH-1:0]       tick,
  output logic [NCH-1:0]       pending
);

  localparam logic [CNT_W-1:0] ONE_C   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] TWO_C   = {{(CNT_W-2){1'b0}}, 2'b10};
  localparam logic [CNT_W-1:0] DEF_RAW = CNT_W'(DEF_RATIO);
  // Ratios below 2 cannot produce both a high and a low phase, so they are
  // raised to 2.
  localparam logic [CNT_W-1:0] DEF_R   = (DEF_RAW < TWO_C) ? TWO_C : DEF_RAW;

  // Raise a requested ratio to the minimum legal value of 2.
  function automatic logic [CNT_W-1:0] clamp_ratio(input logic [CNT_W-1:0] v);
    logic [CNT_W-1:0] res;
    if (v < TWO_C) begin
      res = TWO_C;
    end else begin
      res = v;
    end
    return res;
  endfunction

  // Length of the high phase: (R+1)/2. One extra bit is used so that the
  // largest ratio does not overflow.
  function automatic logic [CNT_W-1:0] high_len(input logic [CNT_W-1:0] r);
    logic [CNT_W:0] sum;
    sum = {1'b0, r} + {{CNT_W{1'b0}}, 1'b1};
    return sum[CNT_W:1];
  endfunction

  for (genvar gi = 0; gi < NCH; gi++) begin : g_ch

    logic [CNT_W-1:0] r_q;
    logic [CNT_W-1:0] r_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] shadow_q;
    logic [CNT_W-1:0] shadow_d;
    logic             pend_q;
    logic             pend_d;
    logic             clk_q;
    logic             clk_d;
    logic             tick_q;
    logic             tick_d;

    logic [CNT_W-1:0] ratio_s;
    logic [CNT_W-1:0] new_r_s;
    logic             boundary_s;

    // Next-state logic for one divider channel.
    always_comb begin
      ratio_s    = clamp_ratio(ratio[gi*CNT_W +: CNT_W]);
      r_d        = r_q;
      cnt_d      = cnt_q;
      shadow_d   = shadow_q;
      pend_d     = pend_q;
      clk_d      = 1'b0;
      tick_d     = 1'b0;
      new_r_s    = r_q;
      boundary_s = 1'b0;

      if (!en[gi]) begin
        // Parked at R-1 so that the first enabled edge is a wrap and starts
        // a clean period with clk_out high and a tick.
        if (load[gi]) begin
          r_d      = ratio_s;
          shadow_d = ratio_s;
          cnt_d    = ratio_s - ONE_C;
          pend_d   = 1'b0;
        end else begin
          cnt_d    = r_q - ONE_C;
        end
      end else begin
        // The >= form keeps the counter bounded even if it were ever
        // disturbed above R-1.
        boundary_s = sync || (cnt_q >= (r_q - ONE_C));
        if (boundary_s) begin
          // Priority at a period boundary: same-edge load, then the pending
          // shadow, then the current ratio.
          if (load[gi]) begin
            new_r_s = ratio_s;
          end else if (pend_q) begin
            new_r_s = shadow_q;
          end else begin
            new_r_s = r_q;
          end
          r_d      = new_r_s;
          shadow_d = new_r_s;
          pend_d   = 1'b0;
          cnt_d    = {CNT_W{1'b0}};
          clk_d    = 1'b1;
          tick_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + ONE_C;
          if (load[gi]) begin
            shadow_d = ratio_s;
            pend_d   = 1'b1;
          end else begin
            shadow_d = shadow_q;
            pend_d   = pend_q;
          end
          // Output is decoded from the next count so it is registered in
          // step with cnt rather than lagging it by a cycle.
          clk_d = (cnt_d < high_len(r_q));
        end
      end
    end

    // Channel state registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        r_q      <= DEF_R;
        shadow_q <= DEF_R;
        cnt_q    <= DEF_R - ONE_C;
        pend_q   <= 1'b0;
        clk_q    <= 1'b0;
        tick_q   <= 1'b0;
      end else begin
        r_q      <= r_d;
        shadow_q <= shadow_d;
        cnt_q    <= cnt_d;
        pend_q   <= pend_d;
        clk_q    <= clk_d;
        tick_q   <= tick_d;
      end
    end

    assign clk_out[gi] = clk_q;
    assign tick[gi]    = tick_q;
    assign pending[gi] = pend_q;

  end : g_ch

endmodule : clk_div_prog

// File: tb/tb_clk_div_prog.sv
// -----------------------------------------------------------------------------
// tb_clk_div_prog
//
// Directed testbench for clk_div_prog (NCH=3, CNT_W=8, DEF_RATIO=2).
// Inputs change 1 time unit after a rising edge; outputs are sampled at the
// same point, so every check sees the result of the edge just taken.
// -----------------------------------------------------------------------------
module tb_clk_div_prog;

  logic        clk;
  logic        reset;
  logic [2:0]  en;
  logic        sync;
  logic [2:0]  load;
  logic [23:0] ratio;
  logic [2:0]  clk_out;
  logic [2:0]  tick;
  logic [2:0]  pending;

  int errors;
  int checks;

  clk_div_prog #(
    .NCH      (3),
    .CNT_W    (8),
    .DEF_RATIO(2)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .en     (en),
    .sync   (sync),
    .load   (load),
    .ratio  (ratio),
    .clk_out(clk_out),
    .tick   (tick),
    .pending(pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reset asserted from time zero: all outputs low, with and without clocks.
  task automatic test_reset();
    #2;
    checks++; if (clk_out !== 3'b000) begin errors++; $display("FAIL reset_clk_out: got %b want 000", clk_out); end
    checks++; if (tick !== 3'b000) begin errors++; $display("FAIL reset_tick: got %b want 000", tick); end
    checks++; if (pending !== 3'b000) begin errors++; $display("FAIL reset_pending: got %b want 000", pending); end
    step();
    step();
    checks++; if (clk_out !== 3'b000) begin errors++; $display("FAIL reset_held_clk_out: got %b want 000", clk_out); end
    checks++; if (tick !== 3'b000) begin errors++; $display("FAIL reset_held_tick: got %b want 000", tick); end
  endtask

  // Default ratio 2: every channel toggles each cycle, tick on odd edges.
  task automatic test_default();
    logic [2:0] exp_v;
    reset = 1'b1;
    en    = 3'b111;
    for (int k = 1; k <= 6; k++) begin
      step();
      exp_v = (k % 2 == 1) ? 3'b111 : 3'b000;
      checks++; if (clk_out !== exp_v) begin errors++; $display("FAIL default_clk_out edge %0d: got %b want %b", k, clk_out, exp_v); end
      checks++; if (tick !== exp_v) begin errors++; $display("FAIL default_tick edge %0d: got %b want %b", k, tick, exp_v); end
    end
  endtask

  // Ratio 5 on ch0 captured mid-period, applied at the next wrap.
  task automatic test_load_pending();
    logic exp_c;
    logic exp_t;
    step();                          // ch0 cnt=0
    load  = 3'b001;
    ratio = {8'd0, 8'd0, 8'd5};
    step();                          // ch0 cnt=1, not a wrap edge
    load  = 3'b000;
    checks++; if (pending[0] !== 1'b1) begin errors++; $display("FAIL load5_pending_set: got %b want 1", pending[0]); end
    checks++; if (clk_out[0] !== 1'b0) begin errors++; $display("FAIL load5_old_period: got %b want 0", clk_out[0]); end
    for (int k = 0; k < 10; k++) begin
      step();
      exp_c = ((k % 5) < 3);
      exp_t = ((k % 5) == 0);
      if (k == 0) begin
        checks++; if (pending[0] !== 1'b0) begin errors++; $display("FAIL load5_pending_clear: got %b want 0", pending[0]); end
      end
      checks++; if (clk_out[0] !== exp_c) begin errors++; $display("FAIL load5_clk_out k=%0d: got %b want %b", k, clk_out[0], exp_c); end
      checks++; if (tick[0] !== exp_t) begin errors++; $display("FAIL load5_tick k=%0d: got %b want %b", k, tick[0], exp_t); end
    end
  endtask

  // ch1: load while disabled applies at once; then 4 then 6 in one period.
  task automatic test_disabled_and_multi_load();
    logic exp_c;
    logic exp_t;
    en = 3'b101;
    step();
    checks++; if (clk_out[1] !== 1'b0) begin errors++; $display("FAIL dis_clk_out: got %b want 0", clk_out[1]); end
    checks++; if (tick[1] !== 1'b0) begin errors++; $display("FAIL dis_tick: got %b want 0", tick[1]); end
    load  = 3'b010;
    ratio = {8'd0, 8'd8, 8'd0};
    step();
    load  = 3'b000;
    checks++; if (pending[1] !== 1'b0) begin errors++; $display("FAIL dis_load_pending: got %b want 0", pending[1]); end
    en = 3'b111;
    step();                          // first enabled edge wraps, R=8
    checks++; if (clk_out[1] !== 1'b1) begin errors++; $display("FAIL en_start_clk_out: got %b want 1", clk_out[1]); end
    checks++; if (tick[1] !== 1'b1) begin errors++; $display("FAIL en_start_tick: got %b want 1", tick[1]); end
    load  = 3'b010;
    ratio = {8'd0, 8'd4, 8'd0};
    step();
    checks++; if (pending[1] !== 1'b1) begin errors++; $display("FAIL multi_pending_first: got %b want 1", pending[1]); end
    ratio = {8'd0, 8'd6, 8'd0};
    step();
    load  = 3'b000;
    checks++; if (pending[1] !== 1'b1) begin errors++; $display("FAIL multi_pending_second: got %b want 1", pending[1]); end
    for (int k = 0; k < 5; k++) step();  // cnt 3..7 at ratio 8
    checks++; if (clk_out[1] !== 1'b0) begin errors++; $display("FAIL ratio8_low_end: got %b want 0", clk_out[1]); end
    for (int k = 0; k < 12; k++) begin
      step();
      exp_c = ((k % 6) < 3);
      exp_t = ((k % 6) == 0);
      if (k == 0) begin
        checks++; if (pending[1] !== 1'b0) begin errors++; $display("FAIL multi_pending_clear: got %b want 0", pending[1]); end
      end
      checks++; if (clk_out[1] !== exp_c) begin errors++; $display("FAIL ratio6_clk_out k=%0d: got %b want %b", k, clk_out[1], exp_c); end
      checks++; if (tick[1] !== exp_t) begin errors++; $display("FAIL ratio6_tick k=%0d: got %b want %b", k, tick[1], exp_t); end
    end
  endtask

  // Sync with same-edge loads, then a sync that also applies a pending ratio.
  task automatic test_sync();
    logic [2:0] exp_c;
    logic [2:0] exp_t;
    load  = 3'b011;
    ratio = {8'd0, 8'd4, 8'd3};
    sync  = 1'b1;
    step();
    sync  = 1'b0;
    load  = 3'b000;
    checks++; if (clk_out !== 3'b111) begin errors++; $display("FAIL sync_load_clk_out: got %b want 111", clk_out); end
    checks++; if (tick !== 3'b111) begin errors++; $display("FAIL sync_load_tick: got %b want 111", tick); end
    for (int k = 0; k < 4; k++) step();
    load  = 3'b001;
    ratio = {8'd0, 8'd0, 8'd6};
    step();                          // ch0 cnt 1 -> 2, not a wrap
    load  = 3'b000;
    checks++; if (pending !== 3'b001) begin errors++; $display("FAIL sync_pre_pending: got %b want 001", pending); end
    sync = 1'b1;
    step();
    sync = 1'b0;
    checks++; if (clk_out !== 3'b111) begin errors++; $display("FAIL sync_clk_out: got %b want 111", clk_out); end
    checks++; if (tick !== 3'b111) begin errors++; $display("FAIL sync_tick: got %b want 111", tick); end
    checks++; if (pending !== 3'b000) begin errors++; $display("FAIL sync_pending: got %b want 000", pending); end
    for (int j = 1; j <= 12; j++) begin
      step();
      exp_c = {((j % 2) < 1), ((j % 4) < 2), ((j % 6) < 3)};
      exp_t = {((j % 2) == 0), ((j % 4) == 0), ((j % 6) == 0)};
      checks++; if (clk_out !== exp_c) begin errors++; $display("FAIL post_sync_clk_out j=%0d: got %b want %b", j, clk_out, exp_c); end
      checks++; if (tick !== exp_t) begin errors++; $display("FAIL post_sync_tick j=%0d: got %b want %b", j, tick, exp_t); end
    end
  endtask

  // Reset asserted between edges while clk_out is high.
  task automatic test_async_reset();
    checks++; if (clk_out !== 3'b111) begin errors++; $display("FAIL pre_reset_high: got %b want 111", clk_out); end
    #3;
    reset = 1'b0;
    #1;
    checks++; if (clk_out !== 3'b000) begin errors++; $display("FAIL async_reset_clk_out: got %b want 000", clk_out); end
    checks++; if (tick !== 3'b000) begin errors++; $display("FAIL async_reset_tick: got %b want 000", tick); end
    checks++; if (pending !== 3'b000) begin errors++; $display("FAIL async_reset_pending: got %b want 000", pending); end
    step();
    step();
    checks++; if (clk_out !== 3'b000) begin errors++; $display("FAIL reset_hold_clk_out: got %b want 000", clk_out); end
    reset = 1'b1;
    step();
    checks++; if (clk_out !== 3'b111) begin errors++; $display("FAIL restart_clk_out: got %b want 111", clk_out); end
    checks++; if (tick !== 3'b111) begin errors++; $display("FAIL restart_tick: got %b want 111", tick); end
    step();
    checks++; if (clk_out !== 3'b000) begin errors++; $display("FAIL restart_low: got %b want 000", clk_out); end
    step();
    checks++; if (clk_out !== 3'b111) begin errors++; $display("FAIL restart_high2: got %b want 111", clk_out); end
  endtask

  // Ratios 0/1 clamp to 2, enable drop mid-period, load on a wrap edge.
  task automatic test_clamp_enable();
    logic [2:0] exp_c;
    logic [2:0] exp_t;
    logic       odd;
    en = 3'b000;
    step();
    checks++; if (clk_out !== 3'b000) begin errors++; $display("FAIL disable_all_clk_out: got %b want 000", clk_out); end
    load  = 3'b111;
    ratio = {8'd7, 8'd1, 8'd0};
    step();
    load  = 3'b000;
    checks++; if (pending !== 3'b000) begin errors++; $display("FAIL clamp_load_pending: got %b want 000", pending); end
    en = 3'b111;
    for (int k = 1; k <= 4; k++) begin
      step();
      odd   = (k % 2 == 1);
      exp_c = {1'b1, odd, odd};
      exp_t = {(k == 1), odd, odd};
      checks++; if (clk_out !== exp_c) begin errors++; $display("FAIL clamp_clk_out k=%0d: got %b want %b", k, clk_out, exp_c); end
      checks++; if (tick !== exp_t) begin errors++; $display("FAIL clamp_tick k=%0d: got %b want %b", k, tick, exp_t); end
    end
    en    = 3'b011;
    load  = 3'b001;
    ratio = {8'd0, 8'd0, 8'd3};
    step();                          // ch0 wrap edge with load; ch2 disabled
    load  = 3'b000;
    checks++; if (clk_out[2] !== 1'b0) begin errors++; $display("FAIL en_drop_clk_out: got %b want 0", clk_out[2]); end
    checks++; if (tick[2] !== 1'b0) begin errors++; $display("FAIL en_drop_tick: got %b want 0", tick[2]); end
    checks++; if (pending[0] !== 1'b0) begin errors++; $display("FAIL wrap_load_pending: got %b want 0", pending[0]); end
    checks++; if (tick[0] !== 1'b1) begin errors++; $display("FAIL wrap_load_tick: got %b want 1", tick[0]); end
    step();
    checks++; if (clk_out[0] !== 1'b1) begin errors++; $display("FAIL ratio3_cnt1: got %b want 1", clk_out[0]); end
    checks++; if (clk_out[2] !== 1'b0) begin errors++; $display("FAIL en_drop_stays_low: got %b want 0", clk_out[2]); end
    step();
    checks++; if (clk_out[0] !== 1'b0) begin errors++; $display("FAIL ratio3_cnt2: got %b want 0", clk_out[0]); end
    step();
    checks++; if (clk_out[0] !== 1'b1) begin errors++; $display("FAIL ratio3_wrap_clk_out: got %b want 1", clk_out[0]); end
    checks++; if (tick[0] !== 1'b1) begin errors++; $display("FAIL ratio3_wrap_tick: got %b want 1", tick[0]); end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    reset  = 1'b0;
    en     = 3'b000;
    sync   = 1'b0;
    load   = 3'b000;
    ratio  = 24'd0;
    test_reset();
    test_default();
    test_load_pending();
    test_disabled_and_multi_load();
    test_sync();
    test_async_reset();
    test_clamp_enable();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_clk_div_prog

// File: doc/clk_div_prog.md
CLK_DIV_PROG -- requirements
Module: clk_div_prog

Interface
REQ-001 Parameter NCH, default 3: number of independent divider channels.
REQ-002 Parameter CNT_W, default 8: counter and ratio width per channel.
REQ-003 Parameter DEF_RATIO, default 2: divide ratio loaded into every channel at reset.
REQ-004 Port clk, input, 1: single clock; all state advances on its rising edge.
REQ-005 Port reset, input, 1: reset is asynchronous and active-low.
REQ-006 Port en, input, NCH: per-channel run enable.
REQ-007 Port sync, input, 1: one-cycle pulse that phase-aligns all enabled channels.
REQ-008 Port load, input, NCH: per-channel strobe that captures a new ratio.
REQ-009 Port ratio, input, NCH*CNT_W: ratio for channel i in bits [i*CNT_W +: CNT_W].
REQ-010 Port clk_out, output, NCH: registered divided clock per channel.
REQ-011 Port tick, output, NCH: registered one-cycle pulse at each clk_out rising transition.
REQ-012 Port pending, output, NCH: a captured ratio is waiting for its period boundary.

Function
REQ-013 Each channel SHALL hold an active ratio R, a counter cnt, a shadow ratio and a pending flag.
REQ-014 Ratio values 0 and 1 (captured or DEF_RATIO) SHALL be clamped to 2.
- Ratio range is 2..2^CNT_W-1.
REQ-015 With en[i]=1, cnt SHALL advance 0,1,...,R-1,0,... once per clk.
- The transition from cnt=R-1 to cnt=0 is the "wrap".
REQ-016 clk_out[i] SHALL be 1 while cnt is in 0..H-1 and 0 while cnt is in H..R-1, where H=(R+1)/2 (integer division).
- Even R gives exactly 50% duty.
- Odd R gives high for one cycle more than low.
REQ-017 clk_out and tick SHALL change on the same clock edge as cnt; they are not derived combinationally.
REQ-018 tick[i] SHALL be 1 for exactly the cycle in which cnt=0 following a wrap, a sync, or an enable start.
REQ-019 With en[i]=0, cnt SHALL be held at R-1, clk_out[i]=0 and tick[i]=0.
- The first enabled edge therefore wraps: cnt=0, clk_out=1, tick=1.
REQ-020 Deasserting en[i] mid-period SHALL force the disabled state on the next edge.
- This truncates the current period without a glitch, since clk_out only goes low.
REQ-021 load[i]=1 on an edge that is not a wrap edge SHALL capture ratio into the shadow and set pending[i].
REQ-022 On the next wrap edge, R SHALL take the shadow value and pending[i] SHALL clear.
- The new ratio governs the period starting at that edge.
REQ-023 load[i]=1 on a wrap edge SHALL apply the new ratio directly to the period starting at that edge; pending[i] stays 0.
REQ-024 Multiple loads before a wrap SHALL leave only the last value pending.
REQ-025 load[i]=1 while en[i]=0 SHALL apply immediately: R updated, cnt=new R-1, pending[i]=0.
REQ-026 sync=1 SHALL force every enabled channel to cnt=0, clk_out=1, tick=1 on that edge.
- Any pending ratio is applied first.
- A same-edge load takes precedence over the pending value.
- Disabled channels ignore sync.
REQ-027 Channels SHALL be fully independent apart from the shared sync.

Reset
REQ-028 reset=0 SHALL immediately, without a clock, force every channel to:
- R=clamp(DEF_RATIO), shadow=R, cnt=R-1;
- clk_out=0, tick=0, pending=0.
REQ-029 Reset deassertion SHALL take effect on the first rising clk edge with reset=1.
- Reset asserted mid-period aborts the period immediately.

Verification
REQ-030 Reset, DEF_RATIO=2, en=3'b111 -> each clk_out toggles every cycle; tick is high on every 2nd cycle, starting on the first edge after en.
REQ-031 Load ratio 5 on ch0 while enabled:
- pending[0]=1 until the next wrap;
- after the wrap, clk_out[0] repeats 1,1,1,0,0;
- tick[0] is high once per 5 cycles.
REQ-032 Loads of 4 then 6 on ch1 within one period -> only 6 takes effect, at the wrap: high 3 cycles, low 3 cycles.
REQ-033 ch0 ratio 3, ch1 ratio 4, both running out of phase; pulse sync -> both channels show cnt=0, clk_out=1, tick=1 on the same edge and remain periodic afterwards.
REQ-034 Drive reset=0 between clock edges with clk_out=1 -> clk_out drops to 0 at once; after release, a period restarts at DEF_RATIO on the first enabled edge.
REQ-035 Load ratio 0 and ratio 1 -> both behave as ratio 2; en toggled low mid-period -> clk_out goes low next edge with no high glitch.
